// File: rtl/conv_edge_collector_if.sv
// Bundle of the east-edge column input and the outgoing word stream.
// The "master" modport is the collector's view; "slave" is the mesh/downstream side.
interface conv_edge_collector_if #(
   parameter int MESH_HEIGHT = 20,
   parameter int DATA_W      = 12,
   parameter int FRAME_COLS  = 20
);
   localparam int ROW_W = (MESH_HEIGHT > 1) ? $clog2(MESH_HEIGHT) : 1;
   localparam int COL_W = (FRAME_COLS > 1) ? $clog2(FRAME_COLS) : 1;

   logic [MESH_HEIGHT*DATA_W-1:0] i_col;
   logic                          i_col_valid;
   logic                          o_col_ready;
   logic [DATA_W-1:0]             o_data;
   logic [ROW_W-1:0]              o_row;
   logic [COL_W-1:0]              o_col;
   logic                          o_valid;
   logic                          i_ready;
   logic                          o_last;
   logic                          o_frame_done;
   logic                          o_overflow;

   modport master (
      input  i_col, i_col_valid, i_ready,
      output o_col_ready, o_data, o_row, o_col, o_valid, o_last, o_frame_done, o_overflow
   );

   modport slave (
      output i_col, i_col_valid, i_ready,
      input  o_col_ready, o_data, o_row, o_col, o_valid, o_last, o_frame_done, o_overflow
   );
endinterface

// File: rtl/conv_edge_collector.sv
// Collects whole columns from the mesh east edge into two ping-pong banks and
// replays them as a column-major word stream tagged with row/column indices.
module conv_edge_collector #(
   parameter int MESH_HEIGHT = 20,
   parameter int DATA_W      = 12,
   parameter int FRAME_COLS  = 20
) (
   input  logic                  ck,
   input  logic                  res,
   conv_edge_collector_if.master bus
);
   localparam int ROW_W    = (MESH_HEIGHT > 1) ? $clog2(MESH_HEIGHT) : 1;
   localparam int COL_W    = (FRAME_COLS > 1) ? $clog2(FRAME_COLS) : 1;
   localparam int COLUMN_W = MESH_HEIGHT * DATA_W;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MESH_HEIGHT - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(FRAME_COLS - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t               state_reg, state_next;
   logic [COLUMN_W-1:0]  bank_reg [2];
   logic                 wr_bank_reg, wr_bank_next;
   logic                 rd_bank_reg, rd_bank_next;
   logic [1:0]           cnt_reg, cnt_next;
   logic [COL_W-1:0]     col_reg, col_next;
   logic [DATA_W-1:0]    data_reg, data_next;
   logic [ROW_W-1:0]     row_reg, row_next;
   logic [COL_W-1:0]     ocol_reg, ocol_next;
   logic                 valid_reg, valid_next;
   logic                 last_reg, last_next;
   logic                 overflow_reg, overflow_next;

   logic                 col_ready;
   logic                 capture;
   logic                 transfer;
   logic                 release_bank;
   logic                 do_load;
   logic                 load_bank;
   logic [ROW_W-1:0]     load_row;
   logic [COL_W-1:0]     load_col;
   logic [COLUMN_W-1:0]  load_src;
   logic [COL_W-1:0]     col_inc;

   assign col_ready = (cnt_reg < 2'd2);
   assign capture   = bus.i_col_valid && col_ready;
   assign transfer  = valid_reg && bus.i_ready;
   assign col_inc   = (col_reg == LAST_COL) ? '0 : col_reg + COL_W'(1);

   // Next-state, counters and output-register loads. A load from the bank being
   // written on this very edge is bypassed from i_col so the first word has
   // one-cycle latency and ping-pong handover has no bubble.
   always_comb begin
      state_next    = state_reg;
      wr_bank_next  = wr_bank_reg;
      rd_bank_next  = rd_bank_reg;
      col_next      = col_reg;
      data_next     = data_reg;
      row_next      = row_reg;
      ocol_next     = ocol_reg;
      valid_next    = valid_reg;
      last_next     = last_reg;
      overflow_next = overflow_reg | (bus.i_col_valid & ~col_ready);
      release_bank  = 1'b0;
      do_load       = 1'b0;
      load_bank     = rd_bank_reg;
      load_row      = '0;
      load_col      = col_reg;
      load_src      = '0;

      if (capture) begin
         wr_bank_next = ~wr_bank_reg;
      end

      case (state_reg)
         IDLE: begin
            if (cnt_reg != 2'd0 || capture) begin
               do_load    = 1'b1;
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (transfer) begin
               if (row_reg == LAST_ROW) begin
                  release_bank = 1'b1;
                  rd_bank_next = ~rd_bank_reg;
                  col_next     = col_inc;
                  if (last_reg) begin
                     valid_next = 1'b0;
                     last_next  = 1'b0;
                     row_next   = '0;
                     state_next = DONE;
                  end else if (cnt_reg == 2'd2 || capture) begin
                     do_load   = 1'b1;
                     load_bank = ~rd_bank_reg;
                     load_col  = col_inc;
                  end else begin
                     valid_next = 1'b0;
                     last_next  = 1'b0;
                     row_next   = '0;
                     state_next = IDLE;
                  end
               end else begin
                  do_load  = 1'b1;
                  load_row = row_reg + ROW_W'(1);
               end
            end
         end
         DONE: begin
            if (cnt_reg != 2'd0) begin
               do_load    = 1'b1;
               state_next = STREAM;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      case ({capture, release_bank})
         2'b10:   cnt_next = cnt_reg + 2'd1;
         2'b01:   cnt_next = cnt_reg - 2'd1;
         default: cnt_next = cnt_reg;
      endcase

      if (do_load) begin
         load_src   = (capture && (wr_bank_reg == load_bank)) ? bus.i_col : bank_reg[load_bank];
         data_next  = load_src[load_row*DATA_W +: DATA_W];
         row_next   = load_row;
         ocol_next  = load_col;
         valid_next = 1'b1;
         last_next  = (load_row == LAST_ROW) && (load_col == LAST_COL);
      end
   end

   // Control and output registers; reset aborts streaming and discards buffered columns.
   always_ff @(posedge ck or negedge res) begin
      if (!res) begin
         state_reg    <= IDLE;
         wr_bank_reg  <= 1'b0;
         rd_bank_reg  <= 1'b0;
         cnt_reg      <= 2'd0;
         col_reg      <= '0;
         data_reg     <= '0;
         row_reg      <= '0;
         ocol_reg     <= '0;
         valid_reg    <= 1'b0;
         last_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wr_bank_reg  <= wr_bank_next;
         rd_bank_reg  <= rd_bank_next;
         cnt_reg      <= cnt_next;
         col_reg      <= col_next;
         data_reg     <= data_next;
         row_reg      <= row_next;
         ocol_reg     <= ocol_next;
         valid_reg    <= valid_next;
         last_reg     <= last_next;
         overflow_reg <= overflow_next;
      end
   end

   // Column banks: a whole column lands in one edge; contents are only
   // meaningful while counted in cnt_reg, so they need no reset.
   always_ff @(posedge ck) begin
      if (capture) begin
         bank_reg[wr_bank_reg] <= bus.i_col;
      end
   end

   assign bus.o_col_ready  = col_ready;
   assign bus.o_data       = data_reg;
   assign bus.o_row        = row_reg;
   assign bus.o_col        = ocol_reg;
   assign bus.o_valid      = valid_reg;
   assign bus.o_last       = last_reg;
   assign bus.o_frame_done = (state_reg == DONE);
   assign bus.o_overflow   = overflow_reg;
endmodule

// File: tb/tb_conv_edge_collector.sv
// Directed, table-driven bench for conv_edge_collector (H=4, W=12, FRAME_COLS=2).
module tb_conv_edge_collector;
   localparam int H  = 4;
   localparam int DW = 12;
   localparam int FC = 2;

   logic ck;
   logic res;
   int   checks;
   int   errors;

   conv_edge_collector_if #(.MESH_HEIGHT(H), .DATA_W(DW), .FRAME_COLS(FC)) bus ();

   conv_edge_collector #(.MESH_HEIGHT(H), .DATA_W(DW), .FRAME_COLS(FC)) dut (
      .ck  (ck),
      .res (res),
      .bus (bus)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   typedef struct {
      bit              cv;
      logic [H*DW-1:0] col;
      bit              rdy;
      bit              ev;
      int              ed;
      int              er;
      int              ec;
      bit              el;
      bit              ecr;
      bit              eo;
      bit              ef;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [H*DW-1:0] mk(int base);
      logic [H*DW-1:0] v;
      v = '0;
      for (int r = 0; r < H; r++) v[r*DW +: DW] = DW'(base + r + 1);
      return v;
   endfunction

   task automatic add(bit cv, logic [H*DW-1:0] col, bit rdy, bit ev, int ed, int er, int ec,
                      bit el, bit ecr, bit eo, bit ef);
      vec_t v;
      v = '{cv, col, rdy, ev, ed, er, ec, el, ecr, eo, ef};
      vecs.push_back(v);
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ck);
      @(negedge ck);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      res = 1'b0;
      bus.i_col = '0;
      bus.i_col_valid = 1'b0;
      bus.i_ready = 1'b0;

      // Single column, ready high
      add(1, mk('h000), 1, 1, 'h001, 0, 0, 0, 1, 0, 0);
      add(0, '0,        1, 1, 'h002, 1, 0, 0, 1, 0, 0);
      add(0, '0,        1, 1, 'h003, 2, 0, 0, 1, 0, 0);
      add(0, '0,        1, 1, 'h004, 3, 0, 0, 1, 0, 0);
      add(0, '0,        1, 0, 0,     0, 0, 0, 1, 0, 0);
      // Back-pressure on the second column of the frame
      add(1, mk('h010), 1, 1, 'h011, 0, 1, 0, 1, 0, 0);
      add(0, '0,        1, 1, 'h012, 1, 1, 0, 1, 0, 0);
      for (int k = 0; k < 5; k++) add(0, '0, 0, 1, 'h012, 1, 1, 0, 1, 0, 0);
      add(0, '0,        1, 1, 'h013, 2, 1, 0, 1, 0, 0);
      add(0, '0,        1, 1, 'h014, 3, 1, 1, 1, 0, 0);
      add(0, '0,        1, 0, 0,     0, 0, 0, 1, 0, 1);
      add(0, '0,        1, 0, 0,     0, 0, 0, 1, 0, 0);
      // Full frame, ping-pong, no bubble
      add(1, mk('h100), 1, 1, 'h101, 0, 0, 0, 1, 0, 0);
      add(1, mk('h200), 1, 1, 'h102, 1, 0, 0, 0, 0, 0);
      add(0, '0,        1, 1, 'h103, 2, 0, 0, 0, 0, 0);
      add(0, '0,        1, 1, 'h104, 3, 0, 0, 0, 0, 0);
      add(0, '0,        1, 1, 'h201, 0, 1, 0, 1, 0, 0);
      add(0, '0,        1, 1, 'h202, 1, 1, 0, 1, 0, 0);
      add(0, '0,        1, 1, 'h203, 2, 1, 0, 1, 0, 0);
      add(0, '0,        1, 1, 'h204, 3, 1, 1, 1, 0, 0);
      add(0, '0,        1, 0, 0,     0, 0, 0, 1, 0, 1);
      add(0, '0,        1, 0, 0,     0, 0, 0, 1, 0, 0);
      // Overflow: three columns with downstream stalled
      add(1, mk('h300), 0, 1, 'h301, 0, 0, 0, 1, 0, 0);
      add(1, mk('h400), 0, 1, 'h301, 0, 0, 0, 0, 0, 0);
      add(1, mk('h500), 0, 1, 'h301, 0, 0, 0, 0, 1, 0);
      add(0, '0,        0, 1, 'h301, 0, 0, 0, 0, 1, 0);
      add(0, '0,        1, 1, 'h302, 1, 0, 0, 0, 1, 0);
      add(0, '0,        1, 1, 'h303, 2, 0, 0, 0, 1, 0);
      add(0, '0,        1, 1, 'h304, 3, 0, 0, 0, 1, 0);
      add(0, '0,        1, 1, 'h401, 0, 1, 0, 1, 1, 0);
      add(0, '0,        1, 1, 'h402, 1, 1, 0, 1, 1, 0);
      add(0, '0,        1, 1, 'h403, 2, 1, 0, 1, 1, 0);
      add(0, '0,        1, 1, 'h404, 3, 1, 1, 1, 1, 0);
      add(0, '0,        1, 0, 0,     0, 0, 0, 1, 1, 1);
      add(0, '0,        1, 0, 0,     0, 0, 0, 1, 1, 0);
      add(0, '0,        1, 0, 0,     0, 0, 0, 1, 1, 0);

      // Reset held for 3 cycles
      @(negedge ck);
      chk("rst_hold_valid", bus.o_valid, 0);
      chk("rst_hold_col_ready", bus.o_col_ready, 1);
      step();
      step();
      res = 1'b1;
      step();
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_col_ready", bus.o_col_ready, 1);
      chk("rst_overflow", bus.o_overflow, 0);
      chk("rst_frame_done", bus.o_frame_done, 0);
      $display("reset: valid=%0b col_ready=%0b overflow=%0b frame_done=%0b",
               bus.o_valid, bus.o_col_ready, bus.o_overflow, bus.o_frame_done);

      // Vector table
      for (int i = 0; i < vecs.size(); i++) begin
         bus.i_col_valid = vecs[i].cv;
         bus.i_col       = vecs[i].col;
         bus.i_ready     = vecs[i].rdy;
         step();
         $display("vec %0d: cv=%0b rdy=%0b -> valid=%0b data=%03h row=%0d col=%0d last=%0b cready=%0b ovf=%0b fd=%0b",
                  i, vecs[i].cv, vecs[i].rdy, bus.o_valid, bus.o_data, bus.o_row, bus.o_col,
                  bus.o_last, bus.o_col_ready, bus.o_overflow, bus.o_frame_done);
         chk($sformatf("v%0d_valid", i), bus.o_valid, vecs[i].ev);
         chk($sformatf("v%0d_col_ready", i), bus.o_col_ready, vecs[i].ecr);
         chk($sformatf("v%0d_overflow", i), bus.o_overflow, vecs[i].eo);
         chk($sformatf("v%0d_frame_done", i), bus.o_frame_done, vecs[i].ef);
         if (vecs[i].ev) begin
            chk($sformatf("v%0d_data", i), bus.o_data, vecs[i].ed);
            chk($sformatf("v%0d_row", i), bus.o_row, vecs[i].er);
            chk($sformatf("v%0d_col", i), bus.o_col, vecs[i].ec);
            chk($sformatf("v%0d_last", i), bus.o_last, vecs[i].el);
         end
      end

      // Reset mid-stream during row 2 of column 0
      bus.i_col_valid = 1'b1;
      bus.i_col       = mk('h600);
      bus.i_ready     = 1'b1;
      step();
      bus.i_col_valid = 1'b0;
      bus.i_col       = '0;
      for (int r = 0; r < 3; r++) begin
         $display("mid: valid=%0b data=%03h row=%0d", bus.o_valid, bus.o_data, bus.o_row);
         chk($sformatf("mid_r%0d_data", r), bus.o_data, 'h601 + r);
         chk($sformatf("mid_r%0d_row", r), bus.o_row, r);
         if (r < 2) step();
      end
      #2 res = 1'b0;
      #1;
      $display("async reset: valid=%0b data=%03h row=%0d col=%0d last=%0b cready=%0b ovf=%0b fd=%0b",
               bus.o_valid, bus.o_data, bus.o_row, bus.o_col, bus.o_last,
               bus.o_col_ready, bus.o_overflow, bus.o_frame_done);
      chk("arst_valid", bus.o_valid, 0);
      chk("arst_data", bus.o_data, 0);
      chk("arst_row", bus.o_row, 0);
      chk("arst_col", bus.o_col, 0);
      chk("arst_last", bus.o_last, 0);
      chk("arst_col_ready", bus.o_col_ready, 1);
      chk("arst_overflow", bus.o_overflow, 0);
      chk("arst_frame_done", bus.o_frame_done, 0);
      step();
      step();
      res = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         $display("post-reset %0d: valid=%0b cready=%0b", k, bus.o_valid, bus.o_col_ready);
         chk($sformatf("post_rst%0d_valid", k), bus.o_valid, 0);
         chk($sformatf("post_rst%0d_col_ready", k), bus.o_col_ready, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv_edge_collector.md
Name: conv_edge_collector

Overview:
- Drains result columns from the east edge of the conv mesh and re-serialises them into a word stream for downstream memory/DMA.
- Each strobe from the mesh delivers one full column: MESH_HEIGHT words of DATA_W bits.
- Two column banks (ping-pong) let the mesh hand over the next column while the previous one streams out.
- Tags every word with row/column indices and marks frame boundaries.

Parameters:
MESH_HEIGHT, 20, rows per column (words per column).
DATA_W, 12, word width; matches the mesh link width.
FRAME_COLS, 20, columns per frame before the column counter wraps.

Ports:
ck  input  1  clock; all state on rising edge.
res  input  1  asynchronous active-low reset.
i_col  input  MESH_HEIGHT*DATA_W  east-edge column; row r occupies bits [r*DATA_W +: DATA_W].
i_col_valid  input  1  column present on i_col this cycle.
o_col_ready  output  1  collector can accept a column this cycle.
o_data  output  DATA_W  stream word.
o_row  output  clog2(MESH_HEIGHT)  row index of o_data.
o_col  output  clog2(FRAME_COLS)  column index of o_data.
o_valid  output  1  o_data/o_row/o_col/o_last valid.
i_ready  input  1  downstream accepts word.
o_last  output  1  final word of frame.
o_frame_done  output  1  one-cycle pulse after the final word of a frame is accepted.
o_overflow  output  1  sticky: a column was offered while not ready.

Behaviour:
- Reset (res=0, async): all outputs 0 except o_col_ready=1. Both banks empty; write bank, read bank, row counter and col counter = 0; FSM in IDLE. Reset mid-stream aborts immediately and discards buffered columns.
- Occupancy cnt is 0..2. o_col_ready = (cnt<2), combinational from registered cnt only.
- Capture: i_col_valid && o_col_ready at an edge copies all of i_col into the write bank in one cycle. The write bank then toggles.
- i_col_valid && !o_col_ready: column dropped, banks untouched, o_overflow set at that edge. o_overflow clears only on reset.
- cnt update per edge: +1 on capture, -1 on release (last row of a bank accepted). At cnt==1 with capture and release on the same edge, cnt stays 1. At cnt==2 capture is refused even if a release occurs that edge.
- FSM states: IDLE, STREAM, DONE.
- IDLE: o_valid=0. If cnt>0 (or a capture this edge), load row 0 of the read bank into the output registers, set o_valid=1, go to STREAM. First word is visible the cycle after the capture edge (1-cycle latency).
- STREAM, handshake rules:
  - o_data, o_row, o_col and o_last are registered.
  - While o_valid=1 && i_ready=0, all output registers hold stable.
  - A word transfers on o_valid && i_ready at an edge.
- STREAM, after a transfer of row r < MESH_HEIGHT-1: load row r+1.
- STREAM, after a transfer of row MESH_HEIGHT-1 (release):
  - Free the read bank and toggle it; row=0.
  - Col increments; wraps to 0 after FRAME_COLS-1.
  - If the word was the last of the frame, go to DONE.
  - Else if another bank is full (counting the post-update cnt, including a same-edge capture), load its row 0 with no bubble.
  - Else o_valid=0 and go to IDLE.
- o_last = 1 exactly when o_row==MESH_HEIGHT-1 && o_col==FRAME_COLS-1.
- DONE: lasts one cycle, o_frame_done=1, o_valid=0. Next state is STREAM if cnt>0 (loads row 0 of the next bank), else IDLE. Captures are still accepted during DONE.
- o_valid never deasserts without a handshake, except on reset.
- Data passes through unchanged: no arithmetic, no width change.
- Order is column-major: rows 0..H-1 of column c, then column c+1.

Test Plan (MESH_HEIGHT=4, DATA_W=12, FRAME_COLS=2 unless noted):
- Reset: hold res=0 for 3 cycles, release -> o_valid=0, o_col_ready=1, o_overflow=0, o_frame_done=0.
- Single column: i_col rows {0x001,0x002,0x003,0x004} at edge 10, i_ready=1 -> o_valid first high cycle 11; words 0x001..0x004 with o_row 0..3, o_col=0; o_valid low at cycle 15.
- Back-pressure: i_ready=0 for 5 cycles mid-column -> o_data holds 0x002 with o_row=1 unchanged; stream resumes with no loss or duplication.
- Full frame plus ping-pong: two columns on consecutive edges, i_ready=1 -> 8 contiguous words with no bubble; o_last only on col1/row3; o_frame_done pulse the following cycle; o_col returns to 0.
- Overflow: i_ready=0 and three consecutive columns -> o_col_ready falls after the second; third dropped; o_overflow=1 and sticky. Then release i_ready -> exactly 8 words out (columns 1 and 2).
- Reset mid-stream: assert res low during row 2 of column 0 -> all outputs 0 within the same cycle. After release no stale words emerge; o_col_ready=1.
